// File: rtl/mem_access_stage.sv
// Memory-access stage: converts ALU results into byte/half/word loads and stores
// over a req/ack data-memory port, producing writeback, store-done and fault pulses.
module mem_access_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [2:0]                funct3,
    input  logic [DATA_WIDTH-1:0]     alu_result,
    input  logic [DATA_WIDTH-1:0]     store_data,
    input  logic [REG_ADDR_WIDTH-1:0] rd,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [DATA_WIDTH-1:0]     dmem_addr,
    output logic [DATA_WIDTH-1:0]     dmem_wdata,
    output logic [DATA_WIDTH/8-1:0]   dmem_be,
    input  logic                      dmem_ack,
    input  logic [DATA_WIDTH-1:0]     dmem_rdata,
    output logic                      wb_valid,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output logic [DATA_WIDTH-1:0]     wb_data,
    output logic                      store_done,
    output logic                      fault,
    output logic [1:0]                fault_code,
    output logic                      stall
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

    state_t                    state, state_n;
    logic [CW-1:0]             count, count_n;
    logic                      req_n, we_n, wbv_n, sdone_n, fault_n;
    logic [DATA_WIDTH-1:0]     addr_n, wdata_n, wbd_n;
    logic [DATA_WIDTH/8-1:0]   be_n;
    logic [REG_ADDR_WIDTH-1:0] wbr_n, lat_rd, lat_rd_n;
    logic [1:0]                code_n, lat_off, lat_off_n;
    logic [2:0]                lat_f3, lat_f3_n;
    logic                      lat_store, lat_store_n;

    logic                      accept, f3_legal, misaligned;
    logic [DATA_WIDTH-1:0]     st_wdata, ld_data;
    logic [DATA_WIDTH/8-1:0]   st_be;
    logic [7:0]                ld_byte;
    logic [15:0]               ld_half;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready;
    assign stall     = req_valid & ~req_ready;

    // Operation legality, alignment and store lane formation from the live request
    always_comb begin
        case (funct3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = mem_read;
            default:                f3_legal = 1'b0;
        endcase
        case (funct3[1:0])
            2'b01:   misaligned = alu_result[0];
            2'b10:   misaligned = |alu_result[1:0];
            default: misaligned = 1'b0;
        endcase
        case (funct3[1:0])
            2'b00: begin
                st_wdata = {4{store_data[7:0]}};
                st_be    = 4'b0001 << alu_result[1:0];
            end
            2'b01: begin
                st_wdata = {2{store_data[15:0]}};
                st_be    = alu_result[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = store_data;
                st_be    = 4'b1111;
            end
        endcase
    end

    // Load extraction uses the offset and size latched at request time
    always_comb begin
        ld_byte = dmem_rdata[{lat_off, 3'b000} +: 8];
        ld_half = lat_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (lat_f3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'b0, ld_byte};
            3'b101:  ld_data = {16'b0, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_comb begin
        state_n     = state;
        count_n     = count;
        req_n       = dmem_req;
        we_n        = dmem_we;
        addr_n      = dmem_addr;
        wdata_n     = dmem_wdata;
        be_n        = dmem_be;
        wbr_n       = wb_rd;
        wbd_n       = wb_data;
        wbv_n       = 1'b0;
        sdone_n     = 1'b0;
        fault_n     = 1'b0;
        code_n      = 2'b00;
        lat_rd_n    = lat_rd;
        lat_f3_n    = lat_f3;
        lat_off_n   = lat_off;
        lat_store_n = lat_store;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!mem_read && !mem_write) begin
                        wbv_n = 1'b1;
                        wbd_n = alu_result;
                        wbr_n = rd;
                    end else if ((mem_read && mem_write) || !f3_legal) begin
                        fault_n = 1'b1;
                        code_n  = 2'b10;
                    end else if (misaligned) begin
                        fault_n = 1'b1;
                        code_n  = 2'b01;
                    end else begin
                        state_n     = BUSY;
                        count_n     = '0;
                        req_n       = 1'b1;
                        we_n        = mem_write;
                        addr_n      = {alu_result[DATA_WIDTH-1:2], 2'b00};
                        wdata_n     = st_wdata;
                        be_n        = mem_write ? st_be : 4'b1111;
                        lat_rd_n    = rd;
                        lat_f3_n    = funct3;
                        lat_off_n   = alu_result[1:0];
                        lat_store_n = mem_write;
                    end
                end
            end
            BUSY: begin
                count_n = count + CW'(1);
                // An ack on the terminal count still completes normally
                if (dmem_ack) begin
                    state_n = IDLE;
                    req_n   = 1'b0;
                    if (lat_store) begin
                        sdone_n = 1'b1;
                    end else begin
                        wbv_n = 1'b1;
                        wbd_n = ld_data;
                        wbr_n = lat_rd;
                    end
                end else if (count == TERM) begin
                    state_n = IDLE;
                    req_n   = 1'b0;
                    fault_n = 1'b1;
                    code_n  = 2'b11;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            store_done <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
            lat_rd     <= '0;
            lat_f3     <= 3'b000;
            lat_off    <= 2'b00;
            lat_store  <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            dmem_req   <= req_n;
            dmem_we    <= we_n;
            dmem_addr  <= addr_n;
            dmem_wdata <= wdata_n;
            dmem_be    <= be_n;
            wb_valid   <= wbv_n;
            wb_rd      <= wbr_n;
            wb_data    <= wbd_n;
            store_done <= sdone_n;
            fault      <= fault_n;
            fault_code <= code_n;
            lat_rd     <= lat_rd_n;
            lat_f3     <= lat_f3_n;
            lat_off    <= lat_off_n;
            lat_store  <= lat_store_n;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized
// operations checked against a behavioural model of the access rules.
module tb_mem_access_stage;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] alu_result = '0, store_data = '0;
    logic [4:0]  rd = '0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        store_done, fault;
    logic [1:0]  fault_code;
    logic        stall;

    int total = 0;
    int bad = 0;

    mem_access_stage #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TIMEOUT), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .alu_result(alu_result), .store_data(store_data), .rd(rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .store_done(store_done), .fault(fault),
        .fault_code(fault_code), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req, we, req_after, ready_after;
        logic [31:0] addr, wdata, wbd;
        logic [3:0]  be;
        logic [4:0]  wbr;
        logic [4:0]  pulses;
        int          latency, stalls, unstable;
    } obs_t;

    // Reference model: access size, outcome class, lane enables, lane data, load value
    function automatic int acc_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    // 0 pass-through, 1 illegal, 2 misaligned, 3 memory access
    function automatic int classify(input logic r, input logic w, input logic [2:0] f3,
                                    input logic [31:0] a);
        if (!r && !w) return 0;
        if (r && w) return 1;
        if (r && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1;
        if (w && !(f3 inside {3'b000, 3'b001, 3'b010})) return 1;
        if ((int'(a[1:0]) % acc_size(f3)) != 0) return 2;
        return 3;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input int off);
        logic [3:0] be;
        be = '0;
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + acc_size(f3)) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] wd;
        for (int i = 0; i < 4; i++) wd[8*i +: 8] = sd[8*(i % acc_size(f3)) +: 8];
        return wd;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input int off,
                                             input logic [31:0] w);
        longint v;
        v = longint'(w >> (8 * off));
        case (f3)
            3'b000: begin v = v & 'hFF;   if (v >= 128)   v = v - 256;   end
            3'b001: begin v = v & 'hFFFF; if (v >= 32768) v = v - 65536; end
            3'b100: v = v & 'hFF;
            3'b101: v = v & 'hFFFF;
            default: v = longint'(w);
        endcase
        return v[31:0];
    endfunction

    // Issues one operation and observes the stage until a pulse appears; ack after 'waits' BUSY cycles
    task automatic run_op(input logic r, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rdi,
                          input logic [31:0] rdv, input int waits, output obs_t o);
        o = '{default: '0};
        req_valid = 1'b1; mem_read = r; mem_write = w; funct3 = f3;
        alu_result = a; store_data = sd; rd = rdi; dmem_rdata = rdv;
        @(posedge clk); #1;
        o.req = dmem_req; o.we = dmem_we; o.addr = dmem_addr;
        o.wdata = dmem_wdata; o.be = dmem_be;
        if (!dmem_req) begin
            req_valid = 1'b0;
            o.pulses = {wb_valid, store_done, fault, fault_code};
            o.wbd = wb_data; o.wbr = wb_rd;
            o.ready_after = req_ready; o.req_after = dmem_req;
            return;
        end
        for (int k = 0; k < 40; k++) begin
            if (stall) o.stalls++;
            if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be} !==
                {o.req, o.we, o.addr, o.wdata, o.be}) o.unstable++;
            dmem_ack = (k == waits);
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            if (wb_valid || store_done || fault) begin
                req_valid = 1'b0;
                o.pulses = {wb_valid, store_done, fault, fault_code};
                o.wbd = wb_data; o.wbr = wb_rd;
                o.ready_after = req_ready; o.req_after = dmem_req;
                o.latency = k + 1;
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #12;
        total++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wb_valid, wb_rd, wb_data,
             store_done, fault, fault_code} !== '0) begin
            bad++; $display("[TB] FAIL reset_outputs got=%h exp=0",
                {dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wb_valid, wb_rd, wb_data,
                 store_done, fault, fault_code});
        end
        total++;
        if ({req_ready, stall} !== 2'b10) begin
            bad++; $display("[TB] FAIL reset_ready got=%b exp=10", {req_ready, stall});
        end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_load_byte;
        obs_t o;
        run_op(1'b1, 1'b0, 3'b000, 32'h0000_1003, '0, 5'd7, 32'h80FF_1234, 0, o);
        total++;
        if ({o.req, o.we, o.addr, o.be} !== {1'b1, 1'b0, 32'h0000_1000, 4'b1111}) begin
            bad++; $display("[TB] FAIL lb_request got=%h exp=%h", {o.req, o.we, o.addr, o.be},
                {1'b1, 1'b0, 32'h0000_1000, 4'b1111});
        end
        total++;
        if ({o.pulses, o.wbr, o.wbd} !== {5'b10000, 5'd7, 32'hFFFF_FF80} || o.latency != 1) begin
            bad++; $display("[TB] FAIL lb_writeback got=%h lat=%0d exp=%h lat=1",
                {o.pulses, o.wbr, o.wbd}, o.latency, {5'b10000, 5'd7, 32'hFFFF_FF80});
        end
        run_op(1'b1, 1'b0, 3'b100, 32'h0000_1003, '0, 5'd8, 32'h80FF_1234, 0, o);
        total++;
        if ({o.pulses, o.wbr, o.wbd} !== {5'b10000, 5'd8, 32'h0000_0080}) begin
            bad++; $display("[TB] FAIL lbu_writeback got=%h exp=%h",
                {o.pulses, o.wbr, o.wbd}, {5'b10000, 5'd8, 32'h0000_0080});
        end
    endtask

    task automatic test_store_half;
        obs_t o;
        run_op(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 5'd9, '0, 3, o);
        total++;
        if ({o.we, o.addr, o.wdata, o.be} !== {1'b1, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100}) begin
            bad++; $display("[TB] FAIL sh_request got=%h exp=%h", {o.we, o.addr, o.wdata, o.be},
                {1'b1, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100});
        end
        total++;
        if (o.stalls != 4 || o.unstable != 0 || o.latency != 4) begin
            bad++; $display("[TB] FAIL sh_stall got stalls=%0d unstable=%0d lat=%0d exp 4/0/4",
                o.stalls, o.unstable, o.latency);
        end
        total++;
        if ({o.pulses, o.wbd, o.ready_after, o.req_after} !== {5'b01000, 32'h0000_0080, 2'b10}) begin
            bad++; $display("[TB] FAIL sh_done got=%h exp=%h", {o.pulses, o.wbd, o.ready_after,
                o.req_after}, {5'b01000, 32'h0000_0080, 2'b10});
        end
    endtask

    task automatic test_misaligned;
        obs_t o;
        run_op(1'b1, 1'b0, 3'b010, 32'h0000_3001, '0, 5'd2, '0, 0, o);
        total++;
        if ({o.req, o.pulses, o.ready_after} !== {1'b0, 5'b00101, 1'b1}) begin
            bad++; $display("[TB] FAIL misaligned got=%b exp=%b", {o.req, o.pulses, o.ready_after},
                {1'b0, 5'b00101, 1'b1});
        end
        @(posedge clk); #1;
        total++;
        if ({fault, fault_code} !== 3'b000) begin
            bad++; $display("[TB] FAIL fault_pulse_width got=%b exp=000", {fault, fault_code});
        end
    endtask

    task automatic test_timeout;
        obs_t o;
        run_op(1'b1, 1'b0, 3'b010, 32'h0000_4000, '0, 5'd5, 32'h1234_5678, 1000, o);
        total++;
        if ({o.pulses, o.req_after} !== {5'b00111, 1'b0} || o.latency != TIMEOUT || o.stalls != TIMEOUT) begin
            bad++; $display("[TB] FAIL timeout got=%b lat=%0d stalls=%0d exp=%b lat=%0d",
                {o.pulses, o.req_after}, o.latency, o.stalls, {5'b00111, 1'b0}, TIMEOUT);
        end
    endtask

    task automatic test_ack_terminal;
        obs_t o;
        run_op(1'b1, 1'b0, 3'b010, 32'h0000_4004, '0, 5'd6, 32'hCAFE_F00D, TIMEOUT - 1, o);
        total++;
        if ({o.pulses, o.wbr, o.wbd} !== {5'b10000, 5'd6, 32'hCAFE_F00D} || o.latency != TIMEOUT) begin
            bad++; $display("[TB] FAIL ack_terminal got=%h lat=%0d exp=%h lat=%0d",
                {o.pulses, o.wbr, o.wbd}, o.latency, {5'b10000, 5'd6, 32'hCAFE_F00D}, TIMEOUT);
        end
    endtask

    task automatic test_back_to_back;
        req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        alu_result = 32'h5; rd = 5'd3;
        @(posedge clk); #1;
        alu_result = 32'h6; rd = 5'd4;
        total++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd3, 32'h5}) begin
            bad++; $display("[TB] FAIL b2b_first got=%h exp=%h", {wb_valid, wb_rd, wb_data},
                {1'b1, 5'd3, 32'h5});
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        total++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd4, 32'h6}) begin
            bad++; $display("[TB] FAIL b2b_second got=%h exp=%h", {wb_valid, wb_rd, wb_data},
                {1'b1, 5'd4, 32'h6});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal;
        obs_t o;
        run_op(1'b1, 1'b0, 3'b011, 32'h0000_5000, '0, 5'd1, '0, 0, o);
        total++;
        if ({o.req, o.pulses} !== {1'b0, 5'b00110}) begin
            bad++; $display("[TB] FAIL illegal_f3 got=%b exp=%b", {o.req, o.pulses}, {1'b0, 5'b00110});
        end
        run_op(1'b1, 1'b1, 3'b010, 32'h0000_5001, '0, 5'd1, '0, 0, o);
        total++;
        if ({o.req, o.pulses} !== {1'b0, 5'b00110}) begin
            bad++; $display("[TB] FAIL illegal_rw got=%b exp=%b", {o.req, o.pulses}, {1'b0, 5'b00110});
        end
    endtask

    task automatic test_reset_busy;
        obs_t o;
        req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
        alu_result = 32'h0000_6000; rd = 5'd11;
        @(posedge clk); #1;
        req_valid = 1'b0;
        total++;
        if (dmem_req !== 1'b1) begin
            bad++; $display("[TB] FAIL rbusy_req got=%b exp=1", dmem_req);
        end
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        total++;
        if ({dmem_req, req_ready, wb_valid, store_done, fault} !== 5'b01000) begin
            bad++; $display("[TB] FAIL rbusy_async got=%b exp=01000",
                {dmem_req, req_ready, wb_valid, store_done, fault});
        end
        @(negedge clk); reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            dmem_ack = 1'b1;
            @(posedge clk); #1;
            total++;
            if ({dmem_req, wb_valid, store_done, fault} !== 4'b0000) begin
                bad++; $display("[TB] FAIL rbusy_late_ack got=%b exp=0000",
                    {dmem_req, wb_valid, store_done, fault});
            end
        end
        dmem_ack = 1'b0;
        run_op(1'b0, 1'b0, 3'b000, 32'h77, '0, 5'd12, '0, 0, o);
        total++;
        if ({o.pulses, o.wbd} !== {5'b10000, 32'h77}) begin
            bad++; $display("[TB] FAIL rbusy_recover got=%h exp=%h", {o.pulses, o.wbd}, {5'b10000, 32'h77});
        end
    endtask

    task automatic test_random;
        obs_t o;
        logic r, w;
        logic [2:0] f3;
        logic [31:0] a, sd, rdv;
        logic [4:0] rdi;
        int waits, kind, off;
        logic [4:0] ep;
        for (int n = 0; n < 40; n++) begin
            r = 1'($urandom_range(0, 1)); w = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a = $urandom; sd = $urandom; rdv = $urandom; rdi = 5'($urandom);
            case ($urandom_range(0, 5))
                0: waits = TIMEOUT - 1;
                1: waits = 100;
                default: waits = $urandom_range(0, 4);
            endcase
            kind = classify(r, w, f3, a);
            off = int'(a[1:0]);
            run_op(r, w, f3, a, sd, rdi, rdv, waits, o);
            case (kind)
                0: ep = 5'b10000;
                1: ep = 5'b00110;
                2: ep = 5'b00101;
                default: ep = (waits >= TIMEOUT) ? 5'b00111 : (w ? 5'b01000 : 5'b10000);
            endcase
            total++;
            if (o.pulses !== ep) begin
                bad++; $display("[TB] FAIL rnd_pulses n=%0d got=%b exp=%b", n, o.pulses, ep);
            end
            if (kind == 0) begin
                total++;
                if ({o.wbr, o.wbd} !== {rdi, a}) begin
                    bad++; $display("[TB] FAIL rnd_pass n=%0d got=%h exp=%h", n, {o.wbr, o.wbd}, {rdi, a});
                end
            end else if (kind == 3) begin
                total++;
                if ({o.req, o.we, o.addr, o.be} !== {1'b1, w, a & 32'hFFFF_FFFC,
                     w ? exp_be(f3, off) : 4'b1111}) begin
                    bad++; $display("[TB] FAIL rnd_request n=%0d got=%h exp=%h", n,
                        {o.req, o.we, o.addr, o.be},
                        {1'b1, w, a & 32'hFFFF_FFFC, w ? exp_be(f3, off) : 4'b1111});
                end
                total++;
                if (o.latency != ((waits >= TIMEOUT) ? TIMEOUT : waits + 1) || o.unstable != 0) begin
                    bad++; $display("[TB] FAIL rnd_latency n=%0d got=%0d unstable=%0d waits=%0d",
                        n, o.latency, o.unstable, waits);
                end
                if (w) begin
                    total++;
                    if (o.wdata !== exp_wdata(f3, sd)) begin
                        bad++; $display("[TB] FAIL rnd_wdata n=%0d got=%h exp=%h", n, o.wdata,
                            exp_wdata(f3, sd));
                    end
                end else if (waits < TIMEOUT) begin
                    total++;
                    if ({o.wbr, o.wbd} !== {rdi, exp_load(f3, off, rdv)}) begin
                        bad++; $display("[TB] FAIL rnd_load n=%0d got=%h exp=%h", n,
                            {o.wbr, o.wbd}, {rdi, exp_load(f3, off, rdv)});
                    end
                end
            end else begin
                total++;
                if (o.req !== 1'b0) begin
                    bad++; $display("[TB] FAIL rnd_noaccess n=%0d got=%b exp=0", n, o.req);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_load_byte;
        test_store_half;
        test_misaligned;
        test_timeout;
        test_ack_terminal;
        test_back_to_back;
        test_illegal;
        test_reset_busy;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
